// File: rtl/io_port_bridge_if.sv
// I/O port bridge bus: MEM-stage OUT/IN signals and the device-side pins.
// The master modport is the core/device side that drives the bridge inputs.
// The slave modport is the bridge itself.
interface io_port_bridge_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  // MEM stage side
  logic                       port_write_in;
  logic                       port_read_in;
  logic [ADDR_WIDTH-1:0]      PORT_in;
  logic [DATA_WIDTH-1:0]      port_data_in;
  logic [DATA_WIDTH-1:0]      port_data_out;
  logic                       stall_out;
  // Device OUT side
  logic                       ext_out_valid_out;
  logic                       ext_out_ready_in;
  logic [ADDR_WIDTH-1:0]      ext_out_port_out;
  logic [DATA_WIDTH-1:0]      ext_out_data_out;
  // Device IN side
  logic                       ext_in_valid_in;
  logic [ADDR_WIDTH-1:0]      ext_in_port_in;
  logic [DATA_WIDTH-1:0]      ext_in_data_in;
  logic [(2**ADDR_WIDTH)-1:0] in_new_flags_out;

  modport master (
    output port_write_in, port_read_in, PORT_in, port_data_in,
    output ext_out_ready_in, ext_in_valid_in, ext_in_port_in, ext_in_data_in,
    input  port_data_out, stall_out, ext_out_valid_out, ext_out_port_out,
    input  ext_out_data_out, in_new_flags_out
  );

  modport slave (
    input  port_write_in, port_read_in, PORT_in, port_data_in,
    input  ext_out_ready_in, ext_in_valid_in, ext_in_port_in, ext_in_data_in,
    output port_data_out, stall_out, ext_out_valid_out, ext_out_port_out,
    output ext_out_data_out, in_new_flags_out
  );
endinterface

// File: rtl/io_port_bridge.sv
// Device-side end of the processor I/O port interface.
// OUT writes drain to the device through a small FIFO (valid/ready); IN data
// from the device is captured into per-port registers with unread flags.
module io_port_bridge #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  io_port_bridge_if.slave bus
);
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;
  localparam int NUM_PORTS = 2 ** ADDR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] fifo_port_q, fifo_port_d;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [PTR_W-1:0]                      head_q, head_d;
  logic [PTR_W-1:0]                      tail_q, tail_d;
  logic [CNT_W-1:0]                      count_q, count_d;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  in_reg_q, in_reg_d;
  logic [NUM_PORTS-1:0]                  flags_q, flags_d;

  logic full_s;
  logic push_s;
  logic pop_s;

  // Next-state for the OUT FIFO and the IN registers/flags.
  always_comb begin
    fifo_port_d = fifo_port_q;
    fifo_data_d = fifo_data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    in_reg_d    = in_reg_q;
    flags_d     = flags_q;

    full_s = (count_q == DEPTH_C);
    push_s = bus.port_write_in & ~full_s;
    pop_s  = (count_q != {CNT_W{1'b0}}) & bus.ext_out_ready_in;

    if (push_s) begin
      fifo_port_d[tail_q] = bus.PORT_in;
      fifo_data_d[tail_q] = bus.port_data_in;
      tail_d              = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end

    if (pop_s) begin
      head_d = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // The clear comes first so a same-edge capture on the same port wins.
    if (bus.port_read_in) begin
      flags_d[bus.PORT_in] = 1'b0;
    end else begin
      flags_d = flags_q;
    end

    if (bus.ext_in_valid_in) begin
      in_reg_d[bus.ext_in_port_in] = bus.ext_in_data_in;
      flags_d[bus.ext_in_port_in]  = 1'b1;
    end else begin
      in_reg_d = in_reg_q;
    end
  end

  // State registers; reset discards queued entries and overrides all events.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_port_q <= '0;
      fifo_data_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      in_reg_q    <= '0;
      flags_q     <= '0;
    end else begin
      fifo_port_q <= fifo_port_d;
      fifo_data_q <= fifo_data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      in_reg_q    <= in_reg_d;
      flags_q     <= flags_d;
    end
  end

  // Head entry is presented straight from storage; IN read has no bypass.
  assign bus.ext_out_valid_out = (count_q != {CNT_W{1'b0}});
  assign bus.ext_out_port_out  = fifo_port_q[head_q];
  assign bus.ext_out_data_out  = fifo_data_q[head_q];
  assign bus.stall_out         = bus.port_write_in & full_s;
  assign bus.port_data_out     = in_reg_q[bus.PORT_in];
  assign bus.in_new_flags_out  = flags_q;
endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge: directed scenarios then random
// traffic, all compared against a queue/array reference model.
module tb_io_port_bridge;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  io_port_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  io_port_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: FIFO as a queue of {port,data}, IN regs and flags.
  logic [AW+DW-1:0] m_q[$];
  logic [DW-1:0]    m_regs[16];
  logic [15:0]      m_flags;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_flags = 16'h0000;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check state.
  task automatic cycle(input logic rst, input logic wr, input logic rd,
                       input logic [AW-1:0] pt, input logic [DW-1:0] pd,
                       input logic rdy, input logic ev,
                       input logic [AW-1:0] ep, input logic [DW-1:0] ed);
    logic full;
    logic popv;
    reset                = rst;
    bus.port_write_in    = wr;
    bus.port_read_in     = rd;
    bus.PORT_in          = pt;
    bus.port_data_in     = pd;
    bus.ext_out_ready_in = rdy;
    bus.ext_in_valid_in  = ev;
    bus.ext_in_port_in   = ep;
    bus.ext_in_data_in   = ed;
    #1;
    full = (m_q.size() == DEPTH);
    check_eq("stall", {31'd0, bus.stall_out}, {31'd0, (wr && full)});
    check_eq("port_data_out", {16'd0, bus.port_data_out}, {16'd0, m_regs[pt]});
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      popv = (m_q.size() != 0) && rdy;
      if (popv) void'(m_q.pop_front());
      if (wr && !full) m_q.push_back({pt, pd});
      if (rd) m_flags[pt] = 1'b0;
      if (ev) begin
        m_regs[ep]  = ed;
        m_flags[ep] = 1'b1;
      end
    end
    #1;
    check_eq("valid", {31'd0, bus.ext_out_valid_out}, {31'd0, (m_q.size() != 0)});
    if (m_q.size() != 0) begin
      check_eq("head_port", {28'd0, bus.ext_out_port_out}, {28'd0, m_q[0][AW+DW-1:DW]});
      check_eq("head_data", {16'd0, bus.ext_out_data_out}, {16'd0, m_q[0][DW-1:0]});
    end
    check_eq("flags", {16'd0, bus.in_new_flags_out}, {16'd0, m_flags});
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, rdy, 1'b0, 4'd0, 16'h0000);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_clear();
    bus.port_write_in = 1'b0; bus.port_read_in = 1'b0; bus.PORT_in = 4'd0;
    bus.port_data_in = 16'h0000; bus.ext_out_ready_in = 1'b0;
    bus.ext_in_valid_in = 1'b0; bus.ext_in_port_in = 4'd0; bus.ext_in_data_in = 16'h0000;
    reset = 1'b1;
    @(posedge clk); #1;

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
    check_eq("rst_valid", {31'd0, bus.ext_out_valid_out}, 32'd0);
    check_eq("rst_port", {28'd0, bus.ext_out_port_out}, 32'd0);
    check_eq("rst_data", {16'd0, bus.ext_out_data_out}, 32'd0);

    // 1: single OUT write, drained immediately
    cycle(1'b0, 1'b1, 1'b0, 4'd3, 16'hABCD, 1'b1, 1'b0, 4'd0, 16'h0000);
    check_eq("t1_data", {16'd0, bus.ext_out_data_out}, 32'h0000ABCD);
    idle(1'b1);
    check_eq("t1_empty", {31'd0, bus.ext_out_valid_out}, 32'd0);

    // 2: fill with ready low, fifth write stalls, then drain and retry
    for (int i = 1; i <= 5; i++)
      cycle(1'b0, 1'b1, 1'b0, 4'(i), 16'(i), 1'b0, 1'b0, 4'd0, 16'h0000);
    check_eq("t2_stall5", {31'd0, bus.stall_out}, 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 4'd5, 16'd5, 1'b1, 1'b0, 4'd0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 4'd5, 16'd5, 1'b1, 1'b0, 4'd0, 16'h0000);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // 3: hold two entries, then push and pop together across the wrap
    cycle(1'b0, 1'b1, 1'b0, 4'd8, 16'h0100, 1'b0, 1'b0, 4'd0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 4'd9, 16'h0101, 1'b0, 1'b0, 4'd0, 16'h0000);
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 1'b1, 1'b0, 4'(i), 16'h0200 + 16'(i), 1'b1, 1'b0, 4'd0, 16'h0000);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // 4: capture port 7, then read it
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 4'd7, 16'h1234);
    check_eq("t4_flag7", {31'd0, bus.in_new_flags_out[7]}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 4'd7, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
    check_eq("t4_flag7_clr", {31'd0, bus.in_new_flags_out[7]}, 32'd0);

    // 5: same-edge read and capture of port 7
    bus.PORT_in = 4'd7; #1;
    check_eq("t5_old", {16'd0, bus.port_data_out}, 32'h00001234);
    cycle(1'b0, 1'b0, 1'b1, 4'd7, 16'h0000, 1'b0, 1'b1, 4'd7, 16'h5555);
    check_eq("t5_flag7", {31'd0, bus.in_new_flags_out[7]}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 4'd7, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);

    // 6: reset with three queued entries mid-handshake
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 1'b0, 4'(i + 10), 16'hC000 + 16'(i), 1'b0, 1'b1, 4'(i), 16'hD000 + 16'(i));
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
    check_eq("t6_valid", {31'd0, bus.ext_out_valid_out}, 32'd0);
    check_eq("t6_flags", {16'd0, bus.in_new_flags_out}, 32'd0);
    for (int p = 0; p < 16; p++) begin
      bus.PORT_in = 4'(p); #1;
      check_eq("t6_reg", {16'd0, bus.port_data_out}, 32'd0);
    end

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
            4'($urandom), 16'($urandom),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 1), 4'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
